// File: rtl/gate_pkg.sv
// Shared definitions for the gate sweep checker.
// Holds the op encoding, the FSM state type and op validation.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic logic op_valid(
    input logic [2:0] op
  );
    return op <= OP_XNOR;
  endfunction

endpackage

// File: rtl/gate_sweep_checker_ref.sv
// Combinational reference gate: reduces the pattern bits by op.
// Ports: op_i (op code), pat_i (pattern), exp_o (expected bit).
module gate_ref
  import gate_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      op_i,
  input  logic [N_IN-1:0] pat_i,
  output logic            exp_o
);

  always_comb begin
    exp_o = 1'b0;
    case (op_i)
      OP_AND:  exp_o = &pat_i;
      OP_OR:   exp_o = |pat_i;
      OP_XOR:  exp_o = ^pat_i;
      OP_NAND: exp_o = ~&pat_i;
      OP_NOR:  exp_o = ~|pat_i;
      OP_XNOR: exp_o = ~^pat_i;
      default: exp_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep checker for an external N_IN-input gate.
// Ports: clk_i, rst_n_i, start_i, op_i, resp_i in; stim_o,
// busy_o, done_o, pass_o, err_cnt_o, first_fail_o out.
module gate_sweep_checker
  import gate_pkg::*;
#(
  parameter int N_IN     = 2,
  parameter int RESP_LAT = 0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  output logic [N_IN-1:0] stim_o,
  input  logic            resp_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [N_IN:0]   err_cnt_o,
  output logic [N_IN-1:0] first_fail_o
);

  localparam logic [N_IN-1:0] PAT_LAST = '1;
  localparam logic [2:0] DRAIN_LAST =
    (RESP_LAT > 0) ? 3'(RESP_LAT - 1) : 3'd0;

  state_e          state_q;
  logic [2:0]      op_q;
  logic [N_IN-1:0] stim_q;
  logic            busy_q;
  logic            done_q;
  logic [2:0]      drain_q;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            seen_q, seen_d;

  logic            exp_w;
  logic            cmp_vld;
  logic            cmp_exp;
  logic [N_IN-1:0] cmp_pat;
  logic            start_ok;
  logic            mism;

  gate_ref #(.N_IN(N_IN)) u_ref (
    .op_i  (op_q),
    .pat_i (stim_q),
    .exp_o (exp_w)
  );

  assign start_ok = start_i && op_valid(op_i) &&
                    (state_q == ST_IDLE ||
                     state_q == ST_DONE);

  // Expected bit and its pattern are delayed to line up
  // with the gate's response latency.
  if (RESP_LAT == 0) begin : g_bypass
    assign cmp_vld = (state_q == ST_DRIVE);
    assign cmp_exp = exp_w;
    assign cmp_pat = stim_q;
  end else begin : g_pipe
    logic [RESP_LAT-1:0] vld_q;
    logic [RESP_LAT-1:0] exp_q;
    logic [N_IN-1:0]     pat_q [RESP_LAT];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        vld_q <= '0;
        exp_q <= '0;
        for (int i = 0; i < RESP_LAT; i++) begin
          pat_q[i] <= '0;
        end
      end else begin
        vld_q[0] <= (state_q == ST_DRIVE);
        exp_q[0] <= exp_w;
        pat_q[0] <= stim_q;
        for (int i = 1; i < RESP_LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
          exp_q[i] <= exp_q[i-1];
          pat_q[i] <= pat_q[i-1];
        end
      end
    end

    assign cmp_vld = vld_q[RESP_LAT-1];
    assign cmp_exp = exp_q[RESP_LAT-1];
    assign cmp_pat = pat_q[RESP_LAT-1];
  end

  assign mism = cmp_vld && (cmp_exp != resp_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_AND;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drain_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state_q <= ST_DRIVE;
            op_q    <= op_i;
            stim_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (stim_q == PAT_LAST) begin
            stim_q  <= '0;
            drain_q <= '0;
            if (RESP_LAT > 0) begin
              state_q <= ST_DRAIN;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            stim_q <= stim_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The pipeline is empty in IDLE/DONE, so a start
  // never coincides with a live comparison.
  always_comb begin
    err_d  = err_q;
    ff_d   = ff_q;
    seen_d = seen_q;
    if (start_ok) begin
      err_d  = '0;
      ff_d   = '0;
      seen_d = 1'b0;
    end else if (mism) begin
      err_d = err_q + 1'b1;
      if (!seen_q) begin
        ff_d   = cmp_pat;
        seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q  <= '0;
      ff_q   <= '0;
      seen_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      ff_q   <= ff_d;
      seen_q <= seen_d;
    end
  end

  assign stim_o       = stim_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = done_q && (err_q == '0);
  assign err_cnt_o    = err_q;
  assign first_fail_o = ff_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: table of sweeps on a 2-input
// instance plus latency and protocol sequences.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 0, start1 = 0, start2 = 0;
  logic [2:0] op0 = 0, op1 = 0, op2 = 0;
  logic       stuck0 = 0;

  logic [1:0] stim0, ff0;
  logic [2:0] err0;
  logic       busy0, done0, pass0, resp0;

  logic [2:0] stim1, ff1, stim2, ff2;
  logic [3:0] err1, err2;
  logic       busy1, done1, pass1, resp1;
  logic       busy2, done2, pass2, resp2;

  logic x1a, x1b, x2a, x2b;

  gate_sweep_checker #(.N_IN(2), .RESP_LAT(0)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start0),
    .op_i(op0), .stim_o(stim0), .resp_i(resp0),
    .busy_o(busy0), .done_o(done0), .pass_o(pass0),
    .err_cnt_o(err0), .first_fail_o(ff0)
  );

  gate_sweep_checker #(.N_IN(3), .RESP_LAT(1)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start1),
    .op_i(op1), .stim_o(stim1), .resp_i(resp1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .err_cnt_o(err1), .first_fail_o(ff1)
  );

  gate_sweep_checker #(.N_IN(3), .RESP_LAT(2)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start2),
    .op_i(op2), .stim_o(stim2), .resp_i(resp2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .err_cnt_o(err2), .first_fail_o(ff2)
  );

  // Gates under test: AND (or stuck-at-0), and XOR behind
  // two flops for the two 3-input instances.
  assign resp0 = stuck0 ? 1'b0 : (stim0[0] & stim0[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1a <= 0; x1b <= 0; x2a <= 0; x2b <= 0;
    end else begin
      x1a <= ^stim1; x1b <= x1a;
      x2a <= ^stim2; x2b <= x2a;
    end
  end
  assign resp1 = x1b;
  assign resp2 = x2b;

  int sel = 0;
  logic       v_busy, v_done, v_pass;
  logic [2:0] v_stim, v_ff;
  logic [3:0] v_err;

  always_comb begin
    v_busy = busy0; v_done = done0; v_pass = pass0;
    v_stim = {1'b0, stim0}; v_ff = {1'b0, ff0};
    v_err  = {1'b0, err0};
    if (sel == 1) begin
      v_busy = busy1; v_done = done1; v_pass = pass1;
      v_stim = stim1; v_ff = ff1; v_err = err1;
    end else if (sel == 2) begin
      v_busy = busy2; v_done = done2; v_pass = pass2;
      v_stim = stim2; v_ff = ff2; v_err = err2;
    end
  end

  typedef struct {
    logic [2:0] op;
    bit         stuck;
    int         err;
    int         ff;
    bit         mid;
  } vec_t;

  typedef struct {
    int err;
    int ff;
  } res_t;

  int   stim_q[$];
  res_t res_q[$];
  int   n_tot = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic drv(input int s, input logic st,
                     input logic [2:0] op);
    case (s)
      0: begin start0 = st; op0 = op; end
      1: begin start1 = st; op1 = op; end
      default: begin start2 = st; op2 = op; end
    endcase
  endtask

  task automatic sweep(input int s, input logic [2:0] op,
                       input int npat, input int lat,
                       input int e_err, input int e_ff,
                       input bit mid);
    res_t r;
    int   e;
    sel = s;
    for (int k = 0; k < npat; k++) stim_q.push_back(k);
    res_q.push_back('{err: e_err, ff: e_ff});
    @(negedge clk);
    drv(s, 1'b1, op);
    @(negedge clk);
    drv(s, 1'b0, op);
    for (int c = 1; c <= npat + lat; c++) begin
      if (mid && c == 2) drv(s, 1'b1, 3'd3);
      if (mid && c == 3) drv(s, 1'b0, op);
      chk("busy", int'(v_busy), 1);
      chk("done_low", int'(v_done), 0);
      if (c <= npat) begin
        e = stim_q.pop_front();
        chk("stim", int'(v_stim), e);
      end
      @(negedge clk);
    end
    chk("busy_end", int'(v_busy), 0);
    chk("done", int'(v_done), 1);
    r = res_q.pop_front();
    chk("err_cnt", int'(v_err), r.err);
    chk("first_fail", int'(v_ff), r.ff);
    chk("pass", int'(v_pass), int'(r.err == 0));
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{3'd0, 1'b0, 0, 0, 1'b0};
    tbl[1] = '{3'd1, 1'b0, 2, 1, 1'b0};
    tbl[2] = '{3'd2, 1'b0, 3, 1, 1'b1};
    tbl[3] = '{3'd3, 1'b0, 4, 0, 1'b0};
    tbl[4] = '{3'd4, 1'b1, 1, 0, 1'b0};
    tbl[5] = '{3'd0, 1'b1, 1, 3, 1'b0};
    tbl[6] = '{3'd5, 1'b1, 2, 0, 1'b0};
    tbl[7] = '{3'd4, 1'b0, 2, 0, 1'b0};

    @(negedge clk);
    chk("rst_stim", int'(stim0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_pass", int'(pass0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_ff", int'(ff0), 0);
    rst_n = 1'b1;

    @(negedge clk);
    drv(0, 1'b1, 3'd6);
    @(negedge clk);
    drv(0, 1'b0, 3'd0);
    chk("op6_busy", int'(busy0), 0);
    @(negedge clk);
    chk("op6_busy2", int'(busy0), 0);
    chk("op6_done", int'(done0), 0);

    for (int i = 0; i < 8; i++) begin
      stuck0 = tbl[i].stuck;
      sweep(0, tbl[i].op, 4, 0, tbl[i].err,
            tbl[i].ff, tbl[i].mid);
    end

    drv(0, 1'b1, 3'd7);
    @(negedge clk);
    drv(0, 1'b0, 3'd0);
    chk("op7_done", int'(done0), 1);
    chk("op7_busy", int'(busy0), 0);
    chk("op7_err", int'(err0), 2);

    sweep(2, 3'd2, 8, 2, 0, 0, 1'b0);
    sweep(1, 3'd2, 8, 1, 5, 1, 1'b0);

    sel = 0;
    stuck0 = 1'b0;
    @(negedge clk);
    drv(0, 1'b1, 3'd1);
    @(negedge clk);
    drv(0, 1'b0, 3'd1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_stim", int'(stim0), 2);
    chk("mid_err", int'(err0), 1);
    chk("mid_ff", int'(ff0), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_stim", int'(stim0), 0);
    chk("ar_busy", int'(busy0), 0);
    chk("ar_done", int'(done0), 0);
    chk("ar_pass", int'(pass0), 0);
    chk("ar_err", int'(err0), 0);
    chk("ar_ff", int'(ff0), 0);
    @(negedge clk);
    chk("ar_hold", int'(busy0), 0);
    rst_n = 1'b1;
    sweep(0, 3'd0, 4, 0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Parametrised exhaustive self-checker for N-input combinational gates. It is the hardware successor to our two-input gate benches. On `start_i` it drives every input pattern 0..2^N_IN−1 to an external gate under test and compares each response against a selectable reference function. It absorbs a configurable response latency, then reports pass/fail, the error count and the first failing pattern. It sits beside any gate or gate-array block as a built-in sweep harness.

## Interface
- `N_IN`, default 2: gate input count, legal 1..8.
- `RESP_LAT`, default 0: cycles from `stim_o` change to a valid `resp_i`, legal 0..4.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  single-cycle start request; honoured only in IDLE or DONE.
- `op_i`  in  3  reference op, sampled on an accepted start: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
- `stim_o`  out  N_IN  registered pattern to the gate under test.
- `resp_i`  in  1  gate under test output.
- `busy_o`  out  1  high while a sweep is in DRIVE or DRAIN.
- `done_o`  out  1  level; high in DONE until the next accepted start or reset.
- `pass_o`  out  1  `err_cnt_o == 0`; meaningful only while `done_o` is high.
- `err_cnt_o`  out  N_IN+1  mismatch count; never saturates, since the maximum is 2^N_IN.
- `first_fail_o`  out  N_IN  first mismatching pattern; 0 if none.

## Operation
- FSM states: IDLE, DRIVE, DRAIN, DONE. Reset state is IDLE.
- Reset values: `stim_o`=0, `busy_o`=0, `done_o`=0, `pass_o`=0, `err_cnt_o`=0, `first_fail_o`=0, op register 0.
- IDLE or DONE with `start_i`=1 and `op_i`≤5:
  - latch op, clear `err_cnt_o`, `first_fail_o`, the fail-seen flag and `done_o`;
  - `stim_o`←0; go to DRIVE.
- `start_i` with `op_i` of 6 or 7 is ignored, with no state change.
- `start_i` in DRIVE or DRAIN is ignored.
- DRIVE: `stim_o` increments by 1 each cycle. After pattern 2^N_IN−1 has been presented for one cycle:
  - go to DRAIN if RESP_LAT>0, else to DONE;
  - `stim_o`←0.
- DRAIN: lasts exactly RESP_LAT cycles, then goes to DONE.
- Expected value: `gate_ref(op, pattern)`, a reduction of the pattern bits by the latched op.
- The expected value and its pattern travel through a RESP_LAT-deep pipeline with a valid bit. At RESP_LAT=0 the pipeline is bypassed.
- Each valid pipeline output compares against `resp_i` on the same edge. On a mismatch:
  - `err_cnt_o` += 1;
  - if no earlier failure, `first_fail_o` ← pattern and the fail-seen flag sets.
- DONE: outputs hold. `pass_o` = (`err_cnt_o`==0).
- Asynchronous reset mid-sweep aborts immediately to reset values. No partial result is retained.

## Timing
- Accepted start in cycle 0. Pattern k is on `stim_o` during cycle k+1.
- `resp_i` for pattern k is sampled at the rising edge ending cycle k+1+RESP_LAT.
- `busy_o` is high for exactly 2^N_IN + RESP_LAT cycles, starting cycle 1.
- `done_o` rises in the cycle after the last `busy_o` cycle.
- A restart from DONE is accepted on the same edge: `done_o` falls and `busy_o` rises one cycle later.

## Structure
- Package `gate_pkg`:
  - op encoding localparams `OP_AND`..`OP_XNOR`;
  - FSM state typedef;
  - function `op_valid`.
- Sub-module `gate_ref`: purely combinational reference gate, parameter N_IN, inputs op and pattern, output expected bit. It is reusable by future gate benches.
- Top module: FSM, pattern counter, latency pipeline, error counter, first-fail capture.

## Test plan
- N_IN=2, RESP_LAT=0, external 2-input AND, op=0:
  - `stim_o` 0,1,2,3 on cycles 1-4;
  - `busy_o` 4 cycles; `done_o` on cycle 5;
  - `pass_o`=1, `err_cnt_o`=0.
- Same AND gate, op=1 (OR) → mismatches at patterns 1 and 2, so `err_cnt_o`=2, `first_fail_o`=1, `pass_o`=0.
- N_IN=3, RESP_LAT=2, XOR gate behind two flops, op=2:
  - `busy_o` 10 cycles;
  - `pass_o`=1;
  - rerun with RESP_LAT=1 on the same gate gives `err_cnt_o`≠0.
- N_IN=2, `resp_i` stuck at 0, op=4 (NOR) → `err_cnt_o`=1, `first_fail_o`=0.
- Protocol checks:
  - `start_i` pulse mid-DRIVE does not alter the sequence;
  - start with op=6 in IDLE leaves `busy_o`=0;
  - restart from DONE clears results.
- `rst_n_i` low during pattern 2:
  - all outputs reach reset values asynchronously;
  - a later start completes normally with correct results.
